// File: rtl/clk_div_ctrl.sv
// Run-time programmable 50%-duty clock divider with glitch-free ratio updates.
// Ratio changes and stops only take effect at the end of a full low phase.
module clk_div_ctrl #(
  parameter int          CNT_W        = 8,
  parameter int unsigned DEFAULT_HALF = 1
) (
  input  logic             clk_in,
  input  logic             srst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_half
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_half;
  logic             pend_valid;

  logic accept;
  logic accept_nz;
  logic at_wrap;
  logic low_end;

  assign accept    = cfg_valid && !pend_valid;
  assign accept_nz = accept && (cfg_half != '0);
  assign at_wrap   = (cnt == cur_half - CNT_W'(1));
  assign low_end   = at_wrap && !clk_out;

  assign cfg_ready = ~pend_valid;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (srst) begin
      state      <= IDLE;
      cnt        <= '0;
      clk_out    <= 1'b0;
      rise_tick  <= 1'b0;
      cfg_err    <= 1'b0;
      cur_half   <= CNT_W'(DEFAULT_HALF);
      pend_half  <= '0;
      pend_valid <= 1'b0;
    end else begin
      rise_tick <= 1'b0;
      cfg_err   <= accept && (cfg_half == '0);
      case (state)
        IDLE: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          if (en) begin
            state     <= RUN;
            clk_out   <= 1'b1;
            rise_tick <= 1'b1;
            // A config taken on the start edge waits for the first low-end.
            if (accept_nz) begin
              pend_half  <= cfg_half;
              pend_valid <= 1'b1;
            end
          end else if (accept_nz) begin
            cur_half <= cfg_half;
          end
        end
        RUN, STOPPING: begin
          if (at_wrap) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          if (low_end) begin
            if (pend_valid) begin
              cur_half   <= pend_half;
              pend_valid <= 1'b0;
            end
            if (state == STOPPING) begin
              clk_out <= 1'b0;
              state   <= IDLE;
            end else begin
              rise_tick <= 1'b1;
              if (!en) state <= STOPPING;
            end
          end else if (state == RUN && !en) begin
            state <= STOPPING;
          end else if (state == STOPPING && en) begin
            state <= RUN;
          end
          if (accept_nz) begin
            pend_half  <= cfg_half;
            pend_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: phase-countdown model compared every
// cycle, plus literal waveform patterns for the directed scenarios.
module tb_clk_div_ctrl;

  logic       clk_in = 1'b0;
  logic       srst = 1'b1;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_half = '0;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_out;
  logic       rise_tick;
  logic       busy;
  logic [7:0] cur_half;

  int vectors = 0;
  int errors  = 0;

  clk_div_ctrl #(.CNT_W(8), .DEFAULT_HALF(1)) dut (
    .clk_in    (clk_in),
    .srst      (srst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_half  (cfg_half),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .rise_tick (rise_tick),
    .busy      (busy),
    .cur_half  (cur_half)
  );

  always #5 clk_in = ~clk_in;

  // Model: tracks cycles left in the current phase rather than a count-up.
  bit         started = 0;
  bit         m_active, m_stop, m_clk, m_rise, m_err, m_pend_v;
  int         m_left;
  logic [7:0] m_h = 8'd1;
  logic [7:0] m_pend_h;

  always @(posedge clk_in) begin : model
    bit acc, acc_nz, last, boundary, was_stop;
    if (srst) begin
      started = 1; m_active = 0; m_stop = 0; m_clk = 0; m_left = 0;
      m_h = 8'd1; m_pend_v = 0; m_pend_h = 0; m_rise = 0; m_err = 0;
    end else begin
      acc    = cfg_valid && !m_pend_v;
      acc_nz = acc && (cfg_half != 0);
      m_rise = 0;
      m_err  = acc && (cfg_half == 0);
      if (!m_active) begin
        if (en) begin
          m_active = 1; m_stop = 0; m_clk = 1; m_rise = 1; m_left = int'(m_h);
          if (acc_nz) begin m_pend_v = 1; m_pend_h = cfg_half; end
        end else if (acc_nz) begin
          m_h = cfg_half;
        end
      end else begin
        was_stop = m_stop;
        last     = (m_left == 1);
        boundary = last && !m_clk;
        if (!last) m_left = m_left - 1;
        else if (m_clk) begin m_clk = 0; m_left = int'(m_h); end
        else begin
          if (m_pend_v) begin m_h = m_pend_h; m_pend_v = 0; end
          if (was_stop) m_active = 0;
          else begin m_clk = 1; m_rise = 1; m_left = int'(m_h); end
        end
        if (was_stop && !boundary && en) m_stop = 0;
        if (!was_stop && !en) m_stop = 1;
        if (acc_nz) begin m_pend_v = 1; m_pend_h = cfg_half; end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (started) begin
      checkOutput("clk_out",   32'(clk_out),   32'(m_clk));
      checkOutput("rise_tick", 32'(rise_tick), 32'(m_rise));
      checkOutput("busy",      32'(busy),      32'(m_active));
      checkOutput("cur_half",  32'(cur_half),  32'(m_h));
      checkOutput("cfg_ready", 32'(cfg_ready), 32'(!m_pend_v));
      checkOutput("cfg_err",   32'(cfg_err),   32'(m_err));
    end
  end

  task automatic applyStimulus(input logic e, input logic v, input logic [7:0] h, input logic r);
    en = e; cfg_valid = v; cfg_half = h; srst = r;
    @(negedge clk_in);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100 && busy; i++) applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
    checkOutput("idle_reached", 32'(busy), 32'd0);
  endtask

  logic [15:0] h_clk, h_rise, h_aux;
  bit          sent7;

  initial begin
    @(negedge clk_in);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
    checkOutput("reset_clk", 32'(clk_out), 32'd0);
    checkOutput("reset_half", 32'(cur_half), 32'd1);
    checkOutput("reset_ready", 32'(cfg_ready), 32'd1);

    $display("[TB] H=1 continuous run");
    h_clk = '0; h_rise = '0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
      h_clk = {h_clk[14:0], clk_out}; h_rise = {h_rise[14:0], rise_tick};
    end
    checkOutput("h1_clk_pattern", 32'(h_clk[5:0]), 32'b101010);
    checkOutput("h1_rise_pattern", 32'(h_rise[5:0]), 32'b101010);
    waitIdle();

    $display("[TB] H=3 configured in IDLE");
    applyStimulus(1'b0, 1'b1, 8'd3, 1'b0);
    checkOutput("idle_cfg_half", 32'(cur_half), 32'd3);
    h_clk = '0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
      h_clk = {h_clk[14:0], clk_out};
    end
    checkOutput("h3_clk_pattern", 32'(h_clk[8:0]), 32'b111000111);
    checkOutput("h3_busy", 32'(busy), 32'd1);
    waitIdle();

    $display("[TB] H=2 with pending 5 then 7");
    applyStimulus(1'b0, 1'b1, 8'd2, 1'b0);
    h_clk = '0; h_aux = '0; sent7 = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 1) applyStimulus(1'b1, 1'b1, 8'd5, 1'b0);
      else if (i >= 2 && !sent7) begin
        sent7 = cfg_ready;
        applyStimulus(1'b1, 1'b1, 8'd7, 1'b0);
      end else applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
      h_clk = {h_clk[14:0], clk_out}; h_aux = {h_aux[14:0], cfg_ready};
      if (i == 4) checkOutput("h5_applied", 32'(cur_half), 32'd5);
    end
    checkOutput("h2_5_clk_pattern", 32'(h_clk[14:0]), 32'b110011111000001);
    checkOutput("h2_5_ready_pattern", 32'(h_aux[14:0]), 32'b100010000000001);
    checkOutput("h7_applied", 32'(cur_half), 32'd7);
    waitIdle();

    $display("[TB] H=4 stop and resume");
    applyStimulus(1'b0, 1'b1, 8'd4, 1'b0);
    h_clk = '0; h_rise = '0; h_aux = '0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i < 2, 1'b0, 8'd0, 1'b0);
      h_clk = {h_clk[14:0], clk_out}; h_rise = {h_rise[14:0], rise_tick};
      h_aux = {h_aux[14:0], busy};
    end
    checkOutput("stop_clk_pattern", 32'(h_clk[9:0]), 32'b1111000000);
    checkOutput("stop_rise_pattern", 32'(h_rise[9:0]), 32'b1000000000);
    checkOutput("stop_busy_pattern", 32'(h_aux[9:0]), 32'b1111111100);
    h_clk = '0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(i < 2 || i >= 6, 1'b0, 8'd0, 1'b0);
      h_clk = {h_clk[14:0], clk_out};
    end
    checkOutput("resume_clk_pattern", 32'(h_clk[11:0]), 32'b111100001111);
    waitIdle();

    $display("[TB] zero config in RUN");
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'd0, 1'b0);
    checkOutput("zero_err_pulse", 32'(cfg_err), 32'd1);
    checkOutput("zero_half_kept", 32'(cur_half), 32'd4);
    checkOutput("zero_ready", 32'(cfg_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    checkOutput("zero_err_clear", 32'(cfg_err), 32'd0);
    waitIdle();

    $display("[TB] H=6 reset mid-period");
    applyStimulus(1'b0, 1'b1, 8'd6, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'd9, 1'b0);
    checkOutput("pend_ready_low", 32'(cfg_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
    checkOutput("srst_clk", 32'(clk_out), 32'd0);
    checkOutput("srst_half", 32'(cur_half), 32'd1);
    checkOutput("srst_ready", 32'(cfg_ready), 32'd1);
    checkOutput("srst_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
    checkOutput("post_srst_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
